// File: rtl/assignment_packer.sv
// Packs four per-point cluster IDs into each IO BRAM word, writes the word back
// over the assignment region and counts how many point assignments changed.

module assignment_packer_lane #(
  parameter int ID_NB = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load,
  input  logic             clear,
  input  logic             lane_used,
  input  logic [ID_NB-1:0] id_i,
  input  logic [ID_NB-1:0] old_i,
  output logic [ID_NB-1:0] merged_o,
  output logic             diff_o
);
  logic [ID_NB-1:0] id_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear) id_q <= '0;
    else if (load)        id_q <= id_i;
  end

  // Unused lanes pass the old byte through so a partial word is left intact.
  assign merged_o = lane_used ? id_q : old_i;
  assign diff_o   = lane_used && (id_q != old_i);
endmodule

module assignment_packer #(
  parameter int ADDR_NB        = 14,
  parameter int WORD_NB        = 32,
  parameter int ID_NB          = 8,
  parameter int BASE_ADDR      = 0,
  parameter int MAX_NUM_POINTS = 4096
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic [15:0]        num_points_i,
  output logic               ready_o,
  input  logic               id_valid_i,
  input  logic [ID_NB-1:0]   id_i,
  output logic               id_ready_o,
  output logic [ADDR_NB-1:0] bram_addr_o,
  input  logic [WORD_NB-1:0] bram_din_i,
  output logic [WORD_NB-1:0] bram_dout_o,
  output logic               bram_we_o,
  output logic [15:0]        changed_count_o
);
  localparam int NUM_LANES = WORD_NB / ID_NB;
  localparam int LANE_NB   = $clog2(NUM_LANES + 1);
  localparam logic [15:0]        MAX_N = 16'(MAX_NUM_POINTS);
  localparam logic [ADDR_NB-1:0] BASE  = ADDR_NB'(BASE_ADDR);

  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_READ, S_CMP, S_DONE} state_t;
  state_t state, state_nxt;

  logic [15:0]         n_q, point_q, chg_q, count_q;
  logic [LANE_NB-1:0]  lane_q;
  logic [ADDR_NB-1:0]  word_q, addr_q;
  logic [WORD_NB-1:0]  dout_q;
  logic                we_q, ready_q;

  logic [15:0] n_eff;
  logic        hs, last_id;
  logic [NUM_LANES-1:0]             diff;
  logic [NUM_LANES-1:0][ID_NB-1:0]  old_lanes, new_lanes;
  logic [15:0] diff_sum;
  logic [16:0] chg_sum;
  logic [15:0] chg_sat;

  assign n_eff     = (num_points_i > MAX_N) ? MAX_N : num_points_i;
  assign hs        = (state == S_COLLECT) && id_valid_i;
  assign last_id   = (lane_q == LANE_NB'(NUM_LANES - 1)) || (point_q + 16'd1 == n_q);
  assign old_lanes = bram_din_i;

  for (genvar j = 0; j < NUM_LANES; j++) begin : g_lane
    assignment_packer_lane #(.ID_NB(ID_NB)) u_lane (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .load      (hs && (lane_q == LANE_NB'(j))),
      .clear     (state == S_CMP),
      .lane_used (lane_q > LANE_NB'(j)),
      .id_i      (id_i),
      .old_i     (old_lanes[j]),
      .merged_o  (new_lanes[j]),
      .diff_o    (diff[j])
    );
  end

  always_comb begin
    diff_sum = '0;
    for (int j = 0; j < NUM_LANES; j++) diff_sum = diff_sum + 16'(diff[j]);
    chg_sum = {1'b0, chg_q} + {1'b0, diff_sum};
    chg_sat = chg_sum[16] ? 16'hFFFF : chg_sum[15:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start_i) state_nxt = (n_eff == 16'd0) ? S_DONE : S_COLLECT;
      S_COLLECT: if (hs && last_id) state_nxt = S_READ;
      S_READ:    state_nxt = S_CMP;
      S_CMP:     state_nxt = (point_q == n_q) ? S_DONE : S_COLLECT;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state   <= S_IDLE;
      n_q     <= '0;
      point_q <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      chg_q   <= '0;
      count_q <= '0;
      addr_q  <= BASE;
      dout_q  <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state <= state_nxt;
      we_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            n_q     <= n_eff;
            point_q <= '0;
            lane_q  <= '0;
            word_q  <= '0;
            chg_q   <= '0;
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_COLLECT: begin
          if (hs) begin
            lane_q  <= lane_q + LANE_NB'(1);
            point_q <= point_q + 16'd1;
            // Address is presented during READ so the old word lands in CMP.
            if (last_id) addr_q <= BASE + word_q;
          end
        end
        S_CMP: begin
          dout_q <= new_lanes;
          we_q   <= 1'b1;
          chg_q  <= chg_sat;
          word_q <= word_q + ADDR_NB'(1);
          lane_q <= '0;
        end
        S_DONE: count_q <= chg_q;
        default: ;
      endcase
    end
  end

  assign ready_o         = ready_q;
  assign id_ready_o      = (state == S_COLLECT);
  assign bram_addr_o     = addr_q;
  assign bram_dout_o     = dout_q;
  assign bram_we_o       = we_q;
  assign changed_count_o = count_q;
endmodule

// File: doc/assignment_packer.md
Name: assignment_packer

Overview:
- Upstream neighbour of the cluster-assignment copy stage.
- Takes the per-point cluster IDs from the nearest-centroid search as a valid/ready stream and packs four IDs into each IO BRAM word.
- Writes the packed words into the cluster-assignment region of IO BRAM.
- Compares every packed word against the word it overwrites and counts how many point assignments changed. The k-means controller uses this count as its convergence test.

Parameters:
- ADDR_NB, 14, IO BRAM address width.
- WORD_NB, 32, IO BRAM word width; holds four lanes.
- ID_NB, 8, cluster ID width; must equal WORD_NB/4.
- BASE_ADDR, 0, first IO BRAM word of the assignment region.
- MAX_NUM_POINTS, 4096, upper bound on points processed per pass.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  begin one pass; sampled only in IDLE
- num_points_i  in  16  number of points in this pass; sampled on start
- ready_o  out  1  high in IDLE
- id_valid_i  in  1  cluster ID stream valid
- id_i  in  ID_NB  cluster ID of the next point, in point order
- id_ready_o  out  1  ID accepted when id_valid_i and id_ready_o are both high
- bram_addr_o  out  ADDR_NB  IO BRAM address (registered)
- bram_din_i  in  WORD_NB  IO BRAM read data
- bram_dout_o  out  WORD_NB  IO BRAM write data
- bram_we_o  out  1  IO BRAM write enable
- changed_count_o  out  16  number of changed assignments in the last completed pass

Behaviour:
- Reset values:
  - ready_o=1, id_ready_o=0, bram_we_o=0.
  - bram_addr_o=BASE_ADDR, bram_dout_o=0, changed_count_o=0.
  - State IDLE; lane, point and word counters = 0.
- Point count: n = min(num_points_i, MAX_NUM_POINTS), latched on start.
- Lane mapping: point 4k+j goes to word BASE_ADDR+k, bits [8j+7:8j].
- BRAM timing: synchronous read with 1-cycle latency. The address registered in cycle N gives valid bram_din_i in cycle N+1.
- States:
  - IDLE:
    - ready_o=1.
    - On start_i: ready_o←0, changed counter←0, counters←0.
    - Go to COLLECT, or if n==0 go straight to DONE.
  - COLLECT:
    - id_ready_o=1.
    - On each handshake, id_i is stored in the current lane and the lane and point counters increment.
    - After the 4th lane, or after point n, go to READ.
    - id_ready_o is 0 in every state other than COLLECT.
  - READ:
    - bram_addr_o=BASE_ADDR+word index, we=0.
    - Go to CMP next cycle.
  - CMP:
    - bram_din_i is valid this cycle.
    - For each valid lane, add 1 to the changed counter if the new ID differs from the old byte.
    - Drive bram_dout_o with the packed word and bram_we_o=1 for exactly one cycle, same address.
    - Lanes beyond point n keep their old byte, taken from bram_din_i, so a partial last word leaves unused lanes unmodified and uncounted.
    - Then increment the word index and clear the lanes.
    - Go to DONE if the point counter equals n, else COLLECT.
  - DONE:
    - Register the changed counter into changed_count_o.
    - Go to IDLE; ready_o=1 on the following cycle.
- changed_count_o holds its value until the next DONE; it does not clear on start.
- start_i outside IDLE is ignored.
- id_valid_i outside COLLECT is not consumed and has no effect.
- The changed counter saturates at 16'hFFFF. This cannot occur with the default MAX_NUM_POINTS.
- Reset mid-pass:
  - Return to IDLE on the next edge; no further BRAM write is issued.
  - Words already written stay written; changed_count_o←0.
- Throughput: 4 IDs per 6 cycles best case (4 COLLECT + READ + CMP).
- No address wrap: the last address written is BASE_ADDR+ceil(n/4)-1.

Test Plan:
- BRAM preloaded with 0; n=8; IDs 0,1,2,3,0,1,2,3 with continuous valid:
  - word0=32'h03020100, word1=32'h03020100.
  - Exactly 2 write pulses; changed_count_o=6.
  - ready_o returns high.
- Rerun the same pass with identical IDs → same words written, changed_count_o=0.
- n=5, old word1=32'hAABBCCDD, 5th ID=0x07 → word1=32'hAABBCC07; changed_count_o includes that lane only; no write beyond BASE_ADDR+1.
- n=0 → no bram_we_o pulse; ready_o low for 2 cycles and then high; changed_count_o=0.
- Bubbles on id_valid_i (valid every 3rd cycle) plus start_i pulsed mid-pass → packing correct, second start ignored, single pass result.
- reset_i asserted one cycle after the first CMP of an 8-point pass → word0 written, word1 untouched; ready_o=1 and changed_count_o=0 after reset.
